// File: rtl/addsub_serial.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB slice first, carry chained between slices.
// start/busy/done handshake; Z and flags update only on the completion edge.
module addsub_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_reg, y_reg, shadow, shadow_nxt;
  logic             carry;
  logic             last;
  logic [CHUNK:0]   csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // Slice k of the operands plus the running carry; the partial sum lives in
  // shadow so Z only ever shows complete results.
  always_comb begin
    last       = (k == KW'(N - 1));
    csum       = {1'b0, a_reg[int'(k)*CHUNK +: CHUNK]}
               + {1'b0, y_reg[int'(k)*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, carry};
    shadow_nxt = shadow;
    shadow_nxt[int'(k)*CHUNK +: CHUNK] = csum[CHUNK-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= '0;
      a_reg    <= '0;
      y_reg    <= '0;
      carry    <= 1'b0;
      shadow   <= '0;
      done     <= 1'b0;
      Z        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        // Subtract is folded in here: A + ~B + ~borrow.
        a_reg <= X;
        y_reg <= sub ? ~Y : Y;
        carry <= sub ? ~cin : cin;
        k     <= '0;
      end else if (state == RUN) begin
        shadow <= shadow_nxt;
        carry  <= csum[CHUNK];
        k      <= k + 1'b1;
        if (last) begin
          k        <= '0;
          Z        <= shadow_nxt;
          cout     <= csum[CHUNK];
          overflow <= (a_reg[WIDTH-1] == y_reg[WIDTH-1]) &&
                      (shadow_nxt[WIDTH-1] != a_reg[WIDTH-1]);
          zero     <= (shadow_nxt == '0);
          done     <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_addsub_serial.sv
// Directed and random checks of addsub_serial at WIDTH=32/CHUNK=8 and WIDTH=16/CHUNK=16.
module tb_addsub_serial;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub, cin;
  logic [31:0] X, Y;
  logic        busy, done, cout, overflow, zero;
  logic [31:0] Z;

  logic        start16, sub16, cin16;
  logic [15:0] X16, Y16;
  logic        busy16, done16, cout16, overflow16, zero16;
  logic [15:0] Z16;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin), .X(X), .Y(Y),
    .busy(busy), .done(done), .Z(Z), .cout(cout), .overflow(overflow), .zero(zero));

  addsub_serial #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .cin(cin16), .X(X16), .Y(Y16),
    .busy(busy16), .done(done16), .Z(Z16), .cout(cout16), .overflow(overflow16), .zero(zero16));

  // Start an op on the 32-bit DUT; returns at the negedge after the accepting edge.
  task automatic start32(input logic [31:0] x, input logic [31:0] y, input logic s, input logic c);
    @(negedge clk);
    X = x; Y = y; sub = s; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges after the accepting edge until done is seen (bounded).
  task automatic wait32(output int cyc);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; sub = 0; cin = 0; X = 0; Y = 0;
    start16 = 0; sub16 = 0; cin16 = 0; X16 = 0; Y16 = 0;
    #12;
    nchk++;
    if ({busy, done, Z, cout, overflow, zero} !== 36'd0) begin
      nfail++;
      $display("FAIL reset_outputs: got busy=%b done=%b Z=%h cout=%b ov=%b zero=%b, want all 0",
               busy, done, Z, cout, overflow, zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_overflow_add();
    int cyc;
    start32(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
    nchk++;
    if (busy !== 1'b1 || Z !== 32'h0) begin
      nfail++; $display("FAIL add_busy_hold: busy=%b Z=%h, want busy=1 Z=00000000", busy, Z);
    end
    wait32(cyc);
    nchk++;
    if (cyc !== 5 || done !== 1'b1 || busy !== 1'b0) begin
      nfail++; $display("FAIL add_latency: cycles=%0d done=%b busy=%b, want 5 1 0", cyc, done, busy);
    end
    nchk++;
    if ({Z, cout, overflow, zero} !== {32'h80000000, 1'b0, 1'b1, 1'b0}) begin
      nfail++; $display("FAIL add_ovf: Z=%h cout=%b ov=%b zero=%b, want 80000000 0 1 0", Z, cout, overflow, zero);
    end
    @(negedge clk);
    nchk++;
    if (done !== 1'b0) begin
      nfail++; $display("FAIL done_pulse_width: done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_carry_ripple();
    int cyc;
    start32(32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
    wait32(cyc);
    nchk++;
    if ({Z, cout, overflow, zero} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
      nfail++; $display("FAIL ripple: Z=%h cout=%b ov=%b zero=%b, want 00000000 1 0 1", Z, cout, overflow, zero);
    end
  endtask

  task automatic test_subtract();
    int cyc;
    start32(32'h5, 32'h7, 1'b1, 1'b0);
    wait32(cyc);
    nchk++;
    if ({Z, cout, overflow} !== {32'hFFFFFFFE, 1'b0, 1'b0}) begin
      nfail++; $display("FAIL sub_neg: Z=%h cout=%b ov=%b, want FFFFFFFE 0 0", Z, cout, overflow);
    end
    start32(32'h80000000, 32'h1, 1'b1, 1'b0);
    wait32(cyc);
    nchk++;
    if ({Z, cout, overflow} !== {32'h7FFFFFFF, 1'b1, 1'b1}) begin
      nfail++; $display("FAIL sub_ovf: Z=%h cout=%b ov=%b, want 7FFFFFFF 1 1", Z, cout, overflow);
    end
    start32(32'h9, 32'h4, 1'b1, 1'b1);
    wait32(cyc);
    nchk++;
    if ({Z, cout, zero} !== {32'h4, 1'b1, 1'b0}) begin
      nfail++; $display("FAIL sub_borrow: Z=%h cout=%b zero=%b, want 00000004 1 0", Z, cout, zero);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start32(32'h1, 32'h2, 1'b0, 1'b0);
    @(negedge clk);
    X = 32'h100; Y = 32'h100; sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 3;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    nchk++;
    if (cyc !== 5 || Z !== 32'h3) begin
      nfail++; $display("FAIL start_ignored: cycles=%0d Z=%h, want 5 00000003", cyc, Z);
    end
    // done cycle: FSM is idle, so this start must be taken
    X = 32'h10; Y = 32'h20; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nchk++;
    if (busy !== 1'b1 || Z !== 32'h3) begin
      nfail++; $display("FAIL done_cycle_accept: busy=%b Z=%h, want 1 00000003", busy, Z);
    end
    wait32(cyc);
    nchk++;
    if (cyc !== 5 || done !== 1'b1 || Z !== 32'h30) begin
      nfail++; $display("FAIL back_to_back: cycles=%0d done=%b Z=%h, want 5 1 00000030", cyc, done, Z);
    end
  endtask

  task automatic test_reset_midop();
    int cyc;
    bit seen;
    start32(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    nchk++;
    if ({busy, done, Z, cout, overflow, zero} !== 36'd0) begin
      nfail++; $display("FAIL midop_reset: busy=%b done=%b Z=%h cout=%b ov=%b zero=%b, want all 0",
                        busy, done, Z, cout, overflow, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    nchk++;
    if (seen !== 1'b0) begin
      nfail++; $display("FAIL no_done_after_reset: activity=%b, want 0", seen);
    end
    start32(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    wait32(cyc);
    nchk++;
    if (cyc !== 5 || Z !== 32'h23456789) begin
      nfail++; $display("FAIL after_reset_op: cycles=%0d Z=%h, want 5 23456789", cyc, Z);
    end
  endtask

  task automatic test_single_chunk();
    int cyc;
    @(negedge clk);
    X16 = 16'hFFFF; Y16 = 16'h1; sub16 = 1'b0; cin16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cyc = 1;
    while (!done16 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    nchk++;
    if (cyc !== 2 || {Z16, cout16, overflow16, zero16} !== {16'h0, 1'b1, 1'b0, 1'b1}) begin
      nfail++; $display("FAIL single_chunk: cycles=%0d Z=%h cout=%b ov=%b zero=%b, want 2 0000 1 0 1",
                        cyc, Z16, cout16, overflow16, zero16);
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [31:0] x, y, yp, ez;
    logic        s, c, c0, ec, eo;
    logic [15:0] x6, y6, yp6, ez6;
    for (int i = 0; i < 1000; i++) begin
      x = $urandom; y = $urandom; s = 1'($urandom); c = 1'($urandom);
      if (i % 10 == 0) y = x;
      yp = s ? ~y : y;
      c0 = s ? ~c : c;
      {ec, ez} = {1'b0, x} + {1'b0, yp} + {32'd0, c0};
      eo = (x[31] == yp[31]) && (ez[31] != x[31]);
      start32(x, y, s, c);
      wait32(cyc);
      nchk++;
      if (cyc !== 5 || {Z, cout, overflow, zero} !== {ez, ec, eo, ez == 32'd0}) begin
        nfail++;
        $display("FAIL rand32 #%0d: cycles=%0d Z=%h c=%b v=%b z=%b, want 5 %h %b %b %b",
                 i, cyc, Z, cout, overflow, zero, ez, ec, eo, ez == 32'd0);
      end
    end
    for (int i = 0; i < 200; i++) begin
      x6 = 16'($urandom); y6 = 16'($urandom); s = 1'($urandom); c = 1'($urandom);
      yp6 = s ? ~y6 : y6;
      c0 = s ? ~c : c;
      {ec, ez6} = {1'b0, x6} + {1'b0, yp6} + {16'd0, c0};
      eo = (x6[15] == yp6[15]) && (ez6[15] != x6[15]);
      @(negedge clk);
      X16 = x6; Y16 = y6; sub16 = s; cin16 = c; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      cyc = 1;
      while (!done16 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      nchk++;
      if (cyc !== 2 || {Z16, cout16, overflow16, zero16} !== {ez6, ec, eo, ez6 == 16'd0}) begin
        nfail++;
        $display("FAIL rand16 #%0d: cycles=%0d Z=%h c=%b v=%b z=%b, want 2 %h %b %b %b",
                 i, cyc, Z16, cout16, overflow16, zero16, ez6, ec, eo, ez6 == 16'd0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overflow_add();
    test_carry_ripple();
    test_subtract();
    test_back_to_back();
    test_reset_midop();
    test_single_chunk();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
